// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, reset PC, branch counter encodings
// and the BTB entry layout used by the fetch stage.
package core_pkg;

    localparam int          CORE_XLEN     = 32;
    localparam logic [31:0] CORE_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_t;

    // Tag is stored zero-extended to the full width so the layout is independent of ENTRIES.
    typedef struct packed {
        logic                 valid;
        logic [CORE_XLEN-1:0] tag;
        logic [CORE_XLEN-1:0] target;
        ctr_t                 ctr;
    } btb_entry_t;

    function automatic ctr_t ctr_update(input ctr_t c, input logic taken);
        ctr_t r;
        if (taken) begin
            r = (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'b01);
        end else begin
            r = (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'b01);
        end
        return r;
    endfunction

endpackage

// File: rtl/btb_array.sv
// Direct-mapped branch target buffer: combinational lookup, synchronous training.
// Storage exists only when FETCH_PRED_EN is defined; otherwise it always predicts not-taken.
module btb_array
    import core_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CORE_XLEN-1:0] rd_pc,
    output logic                 rd_taken,
    output logic [CORE_XLEN-1:0] rd_target,
    input  logic                 upd_valid,
    input  logic [CORE_XLEN-1:0] upd_pc,
    input  logic                 upd_taken,
    input  logic [CORE_XLEN-1:0] upd_target
);

`ifdef FETCH_PRED_EN
    localparam int IDXW = $clog2(ENTRIES);

    btb_entry_t            mem_q [ENTRIES];
    btb_entry_t            rd_entry_s;
    btb_entry_t            upd_entry_s;
    logic [IDXW-1:0]       rd_idx_s;
    logic [IDXW-1:0]       upd_idx_s;
    logic [CORE_XLEN-1:0]  rd_tag_s;
    logic [CORE_XLEN-1:0]  upd_tag_s;
    logic                  upd_hit_s;

    assign rd_idx_s    = rd_pc[IDXW+1:2];
    assign upd_idx_s   = upd_pc[IDXW+1:2];
    assign rd_tag_s    = rd_pc >> (IDXW + 2);
    assign upd_tag_s   = upd_pc >> (IDXW + 2);
    assign rd_entry_s  = mem_q[rd_idx_s];
    assign upd_entry_s = mem_q[upd_idx_s];
    assign upd_hit_s   = upd_entry_s.valid && (upd_entry_s.tag == upd_tag_s);

    assign rd_taken  = rd_entry_s.valid && (rd_entry_s.tag == rd_tag_s) && rd_entry_s.ctr[1];
    assign rd_target = rd_entry_s.target;

    // Training write port; tag/target are left unreset, training during reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i].valid <= 1'b0;
                mem_q[i].ctr   <= CTR_WNT;
            end
        end else if (upd_valid) begin
            if (upd_hit_s) begin
                mem_q[upd_idx_s].ctr <= ctr_update(upd_entry_s.ctr, upd_taken);
                if (upd_taken) begin
                    mem_q[upd_idx_s].target <= upd_target;
                end
            end else if (upd_taken) begin
                mem_q[upd_idx_s].valid  <= 1'b1;
                mem_q[upd_idx_s].tag    <= upd_tag_s;
                mem_q[upd_idx_s].target <= upd_target;
                mem_q[upd_idx_s].ctr    <= CTR_WT;
            end
        end
    end
`else
    logic unused_s;

    assign unused_s  = ^{clk, rst, rd_pc, upd_valid, upd_pc, upd_taken, upd_target};
    assign rd_taken  = 1'b0;
    assign rd_target = {CORE_XLEN{1'b0}};
`endif

endmodule

// File: rtl/fetch_predict_unit.sv
// Fetch stage: PC register, PC+4, next-PC selection and BTB-based prediction.
// Prediction is enabled with FETCH_PRED_EN; without it fetch is always PC+4.
module fetch_predict_unit
    import core_pkg::*;
#(
    parameter int              XLEN     = CORE_XLEN,
    parameter int              ENTRIES  = 16,
    parameter logic [XLEN-1:0] RESET_PC = CORE_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_f,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    output logic [XLEN-1:0] pc_f,
    output logic [XLEN-1:0] pc_plus4_f,
    output logic            pred_taken_f,
    output logic [XLEN-1:0] pred_target_f
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_plus4_s;
    logic [XLEN-1:0] btb_target_s;
    logic            btb_taken_s;

    btb_array #(
        .ENTRIES (ENTRIES)
    ) u_btb (
        .clk        (clk),
        .rst        (rst),
        .rd_pc      (pc_q),
        .rd_taken   (btb_taken_s),
        .rd_target  (btb_target_s),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target)
    );

    assign pc_plus4_s    = pc_q + XLEN'(3'd4);
    assign pc_f          = pc_q;
    assign pc_plus4_f    = pc_plus4_s;
    assign pred_taken_f  = btb_taken_s;
    assign pred_target_f = btb_taken_s ? btb_target_s : pc_plus4_s;

    // Next-PC select: a redirect overrides a stall.
    always_comb begin
        pc_d = pred_target_f;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (stall_f) begin
            pc_d = pc_q;
        end else begin
            pc_d = pred_target_f;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_predict_unit.sv
// Self-checking bench for fetch_predict_unit: directed scenarios plus random traffic
// compared every cycle against a behavioural BTB/PC model.
module tb_fetch_predict_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_f;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc;
    logic        m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];

    always #5 clk = ~clk;

    fetch_predict_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall_f        (stall_f),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .pc_f           (pc_f),
        .pc_plus4_f     (pc_plus4_f),
        .pred_taken_f   (pred_taken_f),
        .pred_target_f  (pred_target_f)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0000_0000;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
            m_tag[i]   = 32'h0;
            m_tgt[i]   = 32'h0;
        end
    endtask

    // One cycle: drive, compare at the falling edge, advance the model at the rising edge.
    task automatic cyc(input logic r, input logic st, input logic rv, input logic [31:0] rpc,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utg);
        int          idx;
        int          ui;
        logic        e_t;
        logic        uhit;
        logic [31:0] e_p4;
        logic [31:0] e_tg;
        rst = r; stall_f = st; redirect_valid = rv; redirect_pc = rpc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg;
        @(negedge clk);
        idx  = int'((m_pc >> 2) % 32'd16);
        e_p4 = m_pc + 32'd4;
`ifdef FETCH_PRED_EN
        e_t  = m_valid[idx] && (m_tag[idx] == (m_pc >> 6)) && (m_ctr[idx] >= 2);
`else
        e_t  = 1'b0;
`endif
        e_tg = e_t ? m_tgt[idx] : e_p4;
        chk("pc_f", pc_f, m_pc);
        chk("pc_plus4_f", pc_plus4_f, e_p4);
        chk("pred_taken_f", {31'b0, pred_taken_f}, {31'b0, e_t});
        chk("pred_target_f", pred_target_f, e_tg);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
`ifdef FETCH_PRED_EN
            if (uv) begin
                ui   = int'((upc >> 2) % 32'd16);
                uhit = m_valid[ui] && (m_tag[ui] == (upc >> 6));
                if (uhit) begin
                    m_ctr[ui] = ut ? ((m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1)
                                   : ((m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1);
                    if (ut) m_tgt[ui] = utg;
                end else if (ut) begin
                    m_valid[ui] = 1'b1;
                    m_tag[ui]   = upc >> 6;
                    m_tgt[ui]   = utg;
                    m_ctr[ui]   = 2;
                end
            end
`endif
            m_pc = rv ? rpc : (st ? m_pc : e_tg);
        end
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic redir(input logic [31:0] a);
        cyc(1'b0, 1'b0, 1'b1, a, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic train(input logic [31:0] a, input logic t, input logic [31:0] tg);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, a, t, tg);
    endtask

    initial begin
        rst = 1'b1; stall_f = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0; upd_target = 32'h0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        chk("reset_pc", pc_f, 32'h0000_0000);
        chk("reset_pred", {31'b0, pred_taken_f}, 32'h0);
        chk("reset_pred_target", pred_target_f, 32'h0000_0004);

        // Sequential fetch.
        idle(); chk("seq_4", pc_f, 32'h0000_0004);
        idle(); chk("seq_8", pc_f, 32'h0000_0008);
        idle(); chk("seq_c", pc_f, 32'h0000_000C);

        // Taken training at 0x10 while fetching 0xC.
        train(32'h10, 1'b1, 32'h40);
        chk("train_pc", pc_f, 32'h0000_0010);
`ifdef FETCH_PRED_EN
        chk("train_pred", {31'b0, pred_taken_f}, 32'h1);
        chk("train_target", pred_target_f, 32'h0000_0040);
        idle(); chk("train_follow", pc_f, 32'h0000_0040);
`else
        chk("train_pred", {31'b0, pred_taken_f}, 32'h0);
        chk("train_target", pred_target_f, 32'h0000_0014);
        idle(); chk("train_follow", pc_f, 32'h0000_0014);
`endif

        // Two not-taken updates drive the counter down to SNT; one taken leaves it WNT.
        cyc(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h10, 1'b0, 32'h0);
        train(32'h10, 1'b0, 32'h0);
        idle(); idle(); idle();
        chk("nt_pc", pc_f, 32'h0000_0010);
        chk("nt_pred", {31'b0, pred_taken_f}, 32'h0);
        chk("nt_target", pred_target_f, 32'h0000_0014);
        train(32'h10, 1'b1, 32'h40);
        chk("nt_next", pc_f, 32'h0000_0014);
        redir(32'h10);
        chk("wnt_pred", {31'b0, pred_taken_f}, 32'h0);

        // Aliasing: 0x50 shares the index of 0x10 and replaces it.
        train(32'h10, 1'b1, 32'h40);
        cyc(1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h50, 1'b1, 32'h80);
        chk("alias_miss_pred", {31'b0, pred_taken_f}, 32'h0);
        chk("alias_miss_target", pred_target_f, 32'h0000_0014);
        redir(32'h50);
`ifdef FETCH_PRED_EN
        chk("alias_hit_target", pred_target_f, 32'h0000_0080);
`else
        chk("alias_hit_target", pred_target_f, 32'h0000_0054);
`endif

        // Redirect wins over stall; stall alone holds.
        cyc(1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("redir_over_stall", pc_f, 32'h0000_0100);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
            chk("stall_hold", pc_f, 32'h0000_0100);
        end

        // Reset beats training; PC wraps at the top of the address space.
        cyc(1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 32'h10, 1'b1, 32'h40);
        chk("rst_pc", pc_f, 32'h0000_0000);
        redir(32'h10);
        chk("rst_discard_pred", {31'b0, pred_taken_f}, 32'h0);
        redir(32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4_f, 32'h0000_0000);
        idle();
        chk("wrap_pc", pc_f, 32'h0000_0000);

        // Random traffic confined to a small address region so the BTB hits often.
        for (int n = 0; n < 3000; n++) begin
            logic        r, st, rv, uv, ut;
            logic [31:0] rpc, upc, utg;
            r   = ($urandom_range(0, 255) == 0);
            st  = ($urandom_range(0, 3) == 0);
            rv  = ($urandom_range(0, 7) == 0);
            uv  = ($urandom_range(0, 1) == 0);
            ut  = ($urandom_range(0, 2) != 0);
            rpc = 32'($urandom_range(0, 255));
            upc = 32'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
            utg = 32'($urandom_range(0, 255));
            cyc(r, st, rv, rpc, uv, upc, ut, utg);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
